m_lsu: RTL and testbench
========================

# m_lsu

M-stage load/store unit: the initiator side of the data-memory port. It accepts one load/store per instruction from the pipeline and checks alignment and range. It then drives a handshaked, variable-latency data memory with a word address, byte enables and lane-replicated write data, and returns sign/zero-extended load data. It holds the pipeline (`stall`) for the whole transaction and raises AdEL/AdES/DBE exceptions instead of issuing bad accesses.

## Interface
Parameters:
- DM_WORDS, 3072: memory depth in words; legal byte addresses are 0 .. DM_WORDS*4-1.
- TIMEOUT, 255: maximum cycles spent in ISSUE+WAIT before a bus error; range 1..65535.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- req_valid  in  1  M-stage holds a load/store; fields stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  2  00 word, 01 byte, 10 half, 11 illegal.
- req_sign  in  1  loads: 1 sign-extend (lb/lh), 0 zero-extend (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (low byte/half used for sb/sh).
- stall  out  1  freeze F/D/E/M; combinational: req_valid & (state != DONE).
- done  out  1  one-cycle completion pulse (registered).
- rdata  out  32  extended load result; valid while done=1, holds until next completion.
- exc  out  1  exception flag, qualified by done.
- exc_code  out  5  4 AdEL, 5 AdES, 7 DBE; 0 when exc=0.
- mem_valid  out  1  request valid.
- mem_we  out  1  write request.
- mem_be  out  4  byte enables.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid this cycle.
- mem_rdata  in  32  raw read word.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset state: IDLE.
- IDLE and req_valid:
  - Error check: op=11, word with addr[1:0]≠0, half with addr[0]=1, or addr ≥ DM_WORDS*4 → DONE, exc=1, code 5 if req_we else 4. No memory request.
  - Otherwise → ISSUE, with timeout counter cleared.
- ISSUE: mem_valid=1, fields constant.
  - mem_ready and store → DONE.
  - mem_ready and load → WAIT, unless mem_rvalid is also 1 in the same cycle; then capture and → DONE.
- WAIT: mem_rvalid → capture the extended data → DONE.
- ISSUE/WAIT timeout: counter increments each cycle in these states. On reaching TIMEOUT with no completing event → DONE, exc=1, code 7, and mem_valid drops. A completing event in the TIMEOUT cycle wins.
- DONE: done=1, stall=0, pipeline advances; → IDLE unconditionally.
- Lanes:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{w[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{w[15:0]}}.
  - word: be = 1111, wdata = w.
  - Load extraction uses the same lane selection, extended per req_sign; word loads pass through unchanged.
- mem_we, mem_be, mem_addr, mem_wdata are registered on entry to ISSUE. Outside ISSUE they are 0, except mem_addr, which holds.
- mem_rvalid is ignored in IDLE, DONE, and ISSUE-for-store.

## Timing
- Reset values: stall follows req_valid (state IDLE); done=0, rdata=0, exc=0, exc_code=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. Counter=0.
- Reset mid-transaction abandons it; the memory is reset on the same signal.
- Minimum latencies, request seen at cycle 0:
  - Error: done at cycle 1.
  - Store with mem_ready at 1: done at 2.
  - Load with ready+rvalid at 1: done at 2.
  - Load with rvalid at k>1: done at k+1.
- Back-to-back: the next request is sampled in the IDLE cycle after DONE, so there is at most one completion every 2 cycles.
- stall=1 in every cycle of IDLE (with req_valid), ISSUE and WAIT; stall=0 exactly in the done cycle.

## Test plan
- Store 0x1234ABCD as sb at addr 0x0000_0006, mem_ready at once → mem_be=0100, mem_wdata=0xCDCDCDCD, mem_addr=0x4, done 2 cycles after request, exc=0.
- lb at 0x3, mem_rdata=0x80FF_FF7F with rvalid 3 cycles after ready → rdata=0xFFFF_FF80. lbu at the same address → 0x0000_0080. stall high until the done cycle.
- lh at addr 0x5 → no mem_valid, done next cycle, exc=1, exc_code=4. sw at 0xBFFC with DM_WORDS=3072 → exc_code=5.
- Load with mem_ready never asserted, TIMEOUT=4 → mem_valid high 4 cycles then low, done with exc_code=7.
- Assert reset=0 during WAIT → all outputs 0 immediately. A late mem_rvalid after release produces no done.
- Two sw requests held back-to-back with mem_ready tied 1 → done every 3 cycles (IDLE, ISSUE, DONE), no lost or duplicated write.

Source files
------------

// File: rtl/m_lsu.sv
// m_lsu: M-stage load/store unit, initiator side of the data-memory port.
// Checks alignment/range of each pipeline load/store, issues a handshaked
// word access with byte enables and lane-replicated store data, and returns
// sign/zero-extended load data. Holds the pipeline for the whole transaction
// and reports AdEL(4)/AdES(5)/DBE(7) instead of issuing bad accesses.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   req_valid/we/op/sign/addr/wdata   pipeline request, stable while stall=1
//   stall              req_valid & (state != DONE), combinational
//   done               one-cycle completion pulse
//   rdata              extended load result, holds until the next load completes
//   exc, exc_code      exception flag and code, qualified by done
//   mem_valid/we/be/addr/wdata        memory request (valid only in ISSUE)
//   mem_ready, mem_rvalid, mem_rdata  memory handshake and read data
module m_lsu #(
    parameter int unsigned DM_WORDS = 3072,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_op,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [4:0]  exc_code,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) * 33'd4;
    localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT - 1);

    state_t      state, state_d;
    logic [15:0] cnt;
    logic [1:0]  op_q;
    logic        sign_q;
    logic [1:0]  lane_q;

    logic        req_bad;
    logic        capture;
    logic        timed_out;
    logic        at_limit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    assign stall     = req_valid & (state != DONE);
    assign mem_valid = (state == ISSUE);
    assign at_limit  = (cnt == CNT_LAST);

    // Alignment and range check on the live request.
    always_comb begin
        req_bad = 1'b0;
        case (req_op)
            2'b00:   req_bad = (req_addr[1:0] != 2'b00);
            2'b10:   req_bad = req_addr[0];
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
        if ({1'b0, req_addr} >= ADDR_LIMIT) begin
            req_bad = 1'b1;
        end
    end

    // Byte enables and lane-replicated store data for the live request.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
        case (req_op)
            2'b01: begin
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'b10: begin
                be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata;
            end
        endcase
    end

    // Load lane extraction uses the request captured on entry to ISSUE.
    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (lane_q)
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            2'd3:    byte_lane = mem_rdata[31:24];
            default: byte_lane = mem_rdata[7:0];
        endcase
        half_lane = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            2'b01:   load_ext = {{24{sign_q & byte_lane[7]}}, byte_lane};
            2'b10:   load_ext = {{16{sign_q & half_lane[15]}}, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next state. A completing event in the last allowed cycle beats the timeout.
    always_comb begin
        state_d   = state;
        capture   = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_bad ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready && mem_we) begin
                    state_d = DONE;
                end else if (mem_ready && mem_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (at_limit) begin
                    timed_out = 1'b1;
                    state_d   = DONE;
                end else if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (at_limit) begin
                    timed_out = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            sign_q    <= 1'b0;
            lane_q    <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            exc       <= 1'b0;
            exc_code  <= '0;
        end else begin
            state    <= state_d;
            done     <= (state_d == DONE);
            exc      <= 1'b0;
            exc_code <= '0;

            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == ISSUE || state == WAIT) begin
                cnt <= cnt + 16'd1;
            end

            // Request fields are frozen on entry to ISSUE; mem_addr holds afterwards.
            if (state == IDLE && state_d == ISSUE) begin
                op_q      <= req_op;
                sign_q    <= req_sign;
                lane_q    <= req_addr[1:0];
                mem_we    <= req_we;
                mem_be    <= be_d;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_wdata <= wdata_d;
            end else if (state_d != ISSUE) begin
                mem_we    <= 1'b0;
                mem_be    <= '0;
                mem_wdata <= '0;
            end

            if (state == IDLE && state_d == DONE) begin
                exc      <= 1'b1;
                exc_code <= req_we ? 5'd5 : 5'd4;
            end
            if (timed_out) begin
                exc      <= 1'b1;
                exc_code <= 5'd7;
            end
            if (capture) begin
                rdata <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: directed bench for m_lsu. A transaction-level model predicts the
// completion cycle, memory request window, exception and load result of each
// request from the access rules; a per-cycle compare process checks the DUT
// against that prediction, and literal expectations pin the model.
module tb_m_lsu;

    localparam int unsigned DMW = 3072;
    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_sign;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, exc;
    logic [31:0] rdata;
    logic [4:0]  exc_code;
    logic        mem_valid, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    m_lsu #(.DM_WORDS(DMW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_op(req_op), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .exc(exc), .exc_code(exc_code),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [31:0] done_at;
        logic [31:0] issue_end;
        logic        exc;
        logic [4:0]  code;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        load_ok;
    } pred_t;

    // Cycle 0 is the IDLE cycle in which the request is presented; memory
    // ready/rvalid pulse only in cycles rdy_at / rv_at (0 = never).
    function automatic pred_t predict(input logic we, input logic [1:0] op, input logic sign,
                                      input logic [31:0] a, input logic [31:0] w,
                                      input int unsigned rdy_at, input int unsigned rv_at,
                                      input logic [31:0] word);
        pred_t p;
        logic bad;
        logic ready_ok;
        int unsigned sh;
        logic [31:0] v;
        p  = '0;
        sh = a % 4;
        bad = (op == 2'd3) || (op == 2'd0 && sh != 0) || (op == 2'd2 && (a % 2) != 0) ||
              (64'(a) >= 64'(DMW) * 64'd4);
        p.addr = a - sh;
        case (op)
            2'd1: begin
                p.be    = 4'(1 << sh);
                p.wdata = (w & 32'hFF) * 32'h0101_0101;
            end
            2'd2: begin
                p.be    = (sh >= 2) ? 4'hC : 4'h3;
                p.wdata = (w & 32'hFFFF) * 32'h0001_0001;
            end
            default: begin
                p.be    = 4'hF;
                p.wdata = w;
            end
        endcase
        if (bad) begin
            p.done_at   = 1;
            p.issue_end = 0;
            p.exc       = 1'b1;
            p.code      = we ? 5'd5 : 5'd4;
            return p;
        end
        ready_ok = (rdy_at >= 1) && (rdy_at <= TMO);
        p.issue_end = ready_ok ? rdy_at : TMO;
        if (ready_ok && (we || (rv_at >= rdy_at && rv_at <= TMO))) begin
            p.done_at = we ? rdy_at + 1 : rv_at + 1;
            if (!we) begin
                p.load_ok = 1'b1;
                case (op)
                    2'd1: begin
                        v = (word >> (8 * sh)) & 32'hFF;
                        if (sign && v >= 32'd128) v = v + 32'hFFFF_FF00;
                    end
                    2'd2: begin
                        v = (word >> (16 * (sh / 2))) & 32'hFFFF;
                        if (sign && v >= 32'd32768) v = v + 32'hFFFF_0000;
                    end
                    default: v = word;
                endcase
                p.rdata = v;
            end
        end else begin
            p.done_at = TMO + 1;
            p.exc     = 1'b1;
            p.code    = 5'd7;
        end
        return p;
    endfunction

    logic        exp_en = 1'b0;
    logic        exp_stall, exp_done, exp_exc, exp_mv, exp_we, chk_wdata, chk_rdata;
    logic [4:0]  exp_code;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_addr, exp_rdata;

    int unsigned cyc = 0;
    int unsigned last_done_cyc = 0, done_cnt = 0, mv_cnt = 0, wr_cnt = 0;
    logic [31:0] seen_rdata, seen_wdata, seen_addr, prev_wr_addr, last_wr_addr, last_wr_data;
    logic [3:0]  seen_be;
    logic [4:0]  seen_code;
    logic        seen_exc;
    logic        ready_tied = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (exp_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("done", 32'(done), 32'(exp_done));
            check("exc", 32'(exc), 32'(exp_exc));
            check("exc_code", 32'(exc_code), 32'(exp_code));
            check("mem_valid", 32'(mem_valid), 32'(exp_mv));
            check("mem_we", 32'(mem_we), 32'(exp_we));
            check("mem_be", 32'(mem_be), 32'(exp_be));
            if (chk_wdata) check("mem_wdata", mem_wdata, exp_wdata);
            if (exp_mv) check("mem_addr", mem_addr, exp_addr);
            if (chk_rdata) check("rdata", rdata, exp_rdata);
        end
        if (reset) begin
            if (done) begin
                last_done_cyc = cyc;
                done_cnt++;
                seen_rdata = rdata;
                seen_exc   = exc;
                seen_code  = exc_code;
            end
            if (mem_valid) begin
                mv_cnt++;
                seen_be    = mem_be;
                seen_wdata = mem_wdata;
                seen_addr  = mem_addr;
                if (mem_ready && mem_we) begin
                    wr_cnt++;
                    prev_wr_addr = last_wr_addr;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                end
            end
        end
    end

    int unsigned txn_start, mv0;

    task automatic run_txn(input logic we, input logic [1:0] op, input logic sign,
                           input logic [31:0] a, input logic [31:0] w,
                           input int unsigned rdy_at, input int unsigned rv_at,
                           input logic [31:0] word);
        pred_t p;
        logic in_issue;
        p = predict(we, op, sign, a, w, rdy_at, rv_at, word);
        txn_start = cyc;
        mv0 = mv_cnt;
        for (int c = 0; c <= int'(p.done_at); c++) begin
            req_valid  = 1'b1;
            req_we     = we;
            req_op     = op;
            req_sign   = sign;
            req_addr   = a;
            req_wdata  = w;
            mem_ready  = ready_tied || (rdy_at != 0 && c == int'(rdy_at));
            mem_rvalid = (rv_at != 0 && c == int'(rv_at));
            mem_rdata  = word;
            in_issue   = (c >= 1) && (c <= int'(p.issue_end));
            exp_en     = 1'b1;
            exp_stall  = (c < int'(p.done_at));
            exp_done   = (c == int'(p.done_at));
            exp_exc    = exp_done && p.exc;
            exp_code   = exp_exc ? p.code : 5'd0;
            exp_mv     = in_issue;
            exp_we     = in_issue && we;
            exp_be     = in_issue ? p.be : 4'd0;
            chk_wdata  = !(in_issue && !we);
            exp_wdata  = in_issue ? p.wdata : 32'd0;
            exp_addr   = p.addr;
            chk_rdata  = exp_done && p.load_ok;
            exp_rdata  = p.rdata;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            req_valid  = 1'b0;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            exp_en     = 1'b1;
            exp_stall  = 1'b0;
            exp_done   = 1'b0;
            exp_exc    = 1'b0;
            exp_code   = 5'd0;
            exp_mv     = 1'b0;
            exp_we     = 1'b0;
            exp_be     = 4'd0;
            chk_wdata  = 1'b1;
            exp_wdata  = 32'd0;
            chk_rdata  = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_exc"}, 32'(exc), 32'd0);
        check({tag, "_code"}, 32'(exc_code), 32'd0);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    int unsigned d0, wc0, dprev;

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 2'd0; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        check_all_zero("reset");
        #1 req_valid = 1'b1;
        #1 check("reset_stall_follows_valid", 32'(stall), 32'd1);
        req_valid = 1'b0;
        #6 reset = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // sb 0x1234ABCD at 0x6, ready at once
        run_txn(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_ABCD, 1, 0, 32'h0);
        check("sb_be", 32'(seen_be), 32'h4);
        check("sb_wdata", seen_wdata, 32'hCDCD_CDCD);
        check("sb_addr", seen_addr, 32'h4);
        check("sb_latency", last_done_cyc - txn_start, 32'd2);
        check("sb_exc", 32'(seen_exc), 32'd0);
        idle(1);

        // lb / lbu at 0x3, rvalid 3 cycles after ready (last allowed cycle)
        run_txn(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 1, 4, 32'h80FF_FF7F);
        check("lb_rdata", seen_rdata, 32'hFFFF_FF80);
        check("lb_latency", last_done_cyc - txn_start, 32'd5);
        idle(1);
        run_txn(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 1, 4, 32'h80FF_FF7F);
        check("lbu_rdata", seen_rdata, 32'h0000_0080);
        idle(1);

        // misaligned lh, out-of-range sw
        run_txn(1'b0, 2'b10, 1'b1, 32'h5, 32'h0, 1, 1, 32'h0);
        check("lh_mis_code", 32'(seen_code), 32'd4);
        check("lh_mis_latency", last_done_cyc - txn_start, 32'd1);
        check("lh_mis_no_request", mv_cnt - mv0, 32'd0);
        idle(1);
        run_txn(1'b1, 2'b00, 1'b0, 32'hBFFC, 32'h55, 1, 0, 32'h0);
        check("sw_range_code", 32'(seen_code), 32'd5);
        idle(1);

        // load with no mem_ready: bus error after TIMEOUT cycles of mem_valid
        run_txn(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 0, 0, 32'h0);
        check("tmo_valid_cycles", mv_cnt - mv0, 32'd4);
        check("tmo_code", 32'(seen_code), 32'd7);
        check("tmo_latency", last_done_cyc - txn_start, 32'd5);
        idle(1);

        // further lanes, edges of the address range, illegal op, late rvalid
        run_txn(1'b1, 2'b10, 1'b0, 32'h2A, 32'hDEAD_BEEF, 2, 0, 32'h0);
        check("sh_be", 32'(seen_be), 32'hC);
        check("sh_wdata", seen_wdata, 32'hBEEF_BEEF);
        run_txn(1'b0, 2'b10, 1'b1, 32'h22, 32'h0, 1, 1, 32'h8001_7FFF);
        check("lh_same_cycle_rdata", seen_rdata, 32'hFFFF_8001);
        check("lh_same_cycle_latency", last_done_cyc - txn_start, 32'd2);
        run_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 2, 32'h8001_F00F);
        check("lhu_rdata", seen_rdata, 32'h0000_F00F);
        run_txn(1'b0, 2'b00, 1'b0, 32'h2FFC, 32'h0, 3, 3, 32'hCAFE_F00D);
        check("lw_last_word", seen_rdata, 32'hCAFE_F00D);
        run_txn(1'b0, 2'b00, 1'b0, 32'h3000, 32'h0, 1, 1, 32'h0);
        check("lw_past_end_code", 32'(seen_code), 32'd4);
        run_txn(1'b1, 2'b11, 1'b0, 32'h8, 32'h0, 1, 0, 32'h0);
        check("illegal_op_store_code", 32'(seen_code), 32'd5);
        run_txn(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 2, 5, 32'h1111_1111);
        check("late_rvalid_dbe", 32'(seen_code), 32'd7);
        idle(2);

        // reset asserted during WAIT
        exp_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_op = 2'b00; req_sign = 1'b0; req_addr = 32'h10;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        check("wait_stall", 32'(stall), 32'd1);
        check("wait_no_valid", 32'(mem_valid), 32'd0);
        d0 = done_cnt;
        #1 reset = 1'b0; req_valid = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("post_reset_no_done", done_cnt - d0, 32'd0);
        check("post_reset_rdata", rdata, 32'd0);
        idle(2);

        // two stores back-to-back with mem_ready tied high
        ready_tied = 1'b1;
        wc0 = wr_cnt;
        run_txn(1'b1, 2'b00, 1'b0, 32'h100, 32'hA5A5_0001, 1, 0, 32'h0);
        dprev = last_done_cyc;
        run_txn(1'b1, 2'b00, 1'b0, 32'h104, 32'h5A5A_0002, 1, 0, 32'h0);
        check("b2b_done_gap", last_done_cyc - dprev, 32'd3);
        check("b2b_write_count", wr_cnt - wc0, 32'd2);
        check("b2b_first_addr", prev_wr_addr, 32'h100);
        check("b2b_second_addr", last_wr_addr, 32'h104);
        check("b2b_second_data", last_wr_data, 32'h5A5A_0002);
        ready_tied = 1'b0;
        idle(2);

        exp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
